expr_result_unpacker: RTL and testbench
=======================================

Name: expr_result_unpacker

Overview:
- Receiver side of the 90-bit packed expression-result bus. The bus carries 18 fields, y0..y17, concatenated MSB-first.
- The block accepts one packed word per frame, then serialises it into 18 per-field beats.
- Each beat is extended to 6 bits according to the field's declared width and signedness.
- Sits between the expression-under-test output and the checker/scoreboard, so results can be compared field by field.

Parameters:
- NUM_FIELDS, 18, number of fields per frame.
- TOTAL_W, 90, packed input width; must equal the sum of the field widths.
- OUT_W, 6, width of the extended output field; must be >= the widest field.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  packed word valid
- in_ready  out  1  unpacker can accept a word
- in_data  in  TOTAL_W  packed word; y0 in bits 89:86, y17 in bits 5:0
- out_valid  out  1  field beat valid
- out_ready  in  1  downstream accepts beat
- out_idx  out  5  field index 0..17
- out_field  out  OUT_W  field value, sign- or zero-extended
- out_signed  out  1  field is a signed field
- out_last  out  1  beat is field 17

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on rst_n.
  - All state clears: FSM=IDLE, shift register=0, idx=0.
  - Outputs during and after reset: out_valid=0, out_idx=0, out_field=0, out_signed=0, out_last=0, in_ready=1.
- Field i descriptor:
  - width w(i) = 4 + (i mod 3), giving the pattern 4,5,6,4,5,6,...
  - signed when (i div 3) is odd, i.e. fields 3-5, 9-11, 15-17.
- FSM states: IDLE, EMIT.
  - IDLE: in_ready=1, out_valid=0. On in_valid, capture in_data into the 90-bit shift register, set idx=0, go to EMIT.
  - EMIT: out_valid=1.
    - out_field = top w(idx) bits of the shift register, sign-extended if signed, else zero-extended, to OUT_W.
    - out_signed = signedness of field idx.
    - out_last = (idx==17).
  - Beat accepted (out_valid && out_ready), not last: shift register left by w(idx) and increment idx.
  - Beat accepted, last: if in_valid, capture the new word and stay in EMIT with idx=0; otherwise go to IDLE.
- in_ready is 1 in IDLE, and in EMIT only when (out_last && out_ready). This gives back-to-back frames with no bubble.
- Latency: word accepted in cycle N -> field 0 valid in cycle N+1. Minimum 18 cycles per frame.
- Backpressure: while out_valid && !out_ready, out_idx, out_field, out_signed and out_last hold stable.
- in_data is ignored when in_ready=0. No internal buffering beyond one word.
- Reset mid-frame aborts the frame immediately. The partial frame is discarded with no further beats.
- Shift is a variable 4/5/6-bit left shift, zero-filled.

Optional Feature:
- Macro EXPR_UNPACK_XSUM_EN.
- When defined:
  - Extra output out_xsum [OUT_W-1:0] = XOR of all out_field values of the frame, including the current beat.
  - The accumulator resets to 0 on each word capture and is valid when out_last=1.
  - Reset value is 0.
- When undefined: the port and accumulator are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package expr_bus_pkg:
  - constants NUM_FIELDS=18, TOTAL_W=90, OUT_W=6;
  - function field_width(idx);
  - function field_signed(idx);
  - typedef field_t = logic [OUT_W-1:0].
- A future packer on the transmit side uses the same package.
- One sub-module, expr_field_extend: combinational; takes the top 6 bits, width and signedness, and returns the extended field_t.

Test Plan:
- in_data=0, out_ready=1 -> 18 beats, idx 0..17, all out_field=0, out_last only on idx 17, in_ready high on that cycle.
- Decode check on a single word:
  - in_data with bits 74:71 = 4'b1000 (y3) -> beat 3 out_field=6'b111000, out_signed=1.
  - Same word with bits 89:86 = 4'b1000 (y0) -> beat 0 out_field=6'b001000, out_signed=0.
- in_data all ones -> unsigned beats give 15/31/63 and signed beats give 6'b111111.
- out_ready low for 3 cycles at idx 5 -> idx, field and valid stable across those cycles; idx 6 follows on the release cycle.
- rst_n asserted at idx 9 -> out_valid=0 immediately, in_ready=1. A new word after release starts at idx 0.
- Two words presented continuously -> 36 consecutive beats with no idle cycle. With EXPR_UNPACK_XSUM_EN, out_xsum at each out_last equals the software XOR of that frame's 18 fields.

Source files
------------

// File: rtl/expr_bus_pkg.sv
// Shared definitions for the 90-bit packed expression-result bus.
// Used by the receive-side unpacker and by the transmit-side packer.
package expr_bus_pkg;

    localparam int unsigned NUM_FIELDS = 18;
    localparam int unsigned TOTAL_W    = 90;
    localparam int unsigned OUT_W      = 6;
    localparam int unsigned IDX_W      = 5;
    localparam int unsigned FW_W       = 3;

    typedef logic [OUT_W-1:0] field_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    // Field widths repeat 4,5,6 across the bus.
    function automatic logic [FW_W-1:0] field_width(input logic [IDX_W-1:0] idx);
        return FW_W'(32'd4 + 32'(idx % IDX_W'(3)));
    endfunction

    // Every other group of three fields is signed (3-5, 9-11, 15-17).
    function automatic logic field_signed(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] grp;
        grp = idx / IDX_W'(3);
        return grp[0];
    endfunction

endpackage

// File: rtl/expr_field_extend.sv
// Extends a 4/5/6-bit field, left-aligned in a 6-bit slice, to field_t.
module expr_field_extend
    import expr_bus_pkg::*;
(
    input  logic [OUT_W-1:0] top_bits_i,
    input  logic [FW_W-1:0]  width_i,
    input  logic             signed_i,
    output field_t           field_o
);

    // Right-align the field and fill the upper bits with sign or zero.
    always_comb begin
        field_o = top_bits_i;
        case (width_i)
            FW_W'(4): field_o = {{2{signed_i & top_bits_i[5]}}, top_bits_i[5:2]};
            FW_W'(5): field_o = {signed_i & top_bits_i[5], top_bits_i[5:1]};
            default:  field_o = top_bits_i;
        endcase
    end

endmodule

// File: rtl/expr_result_unpacker.sv
// Serialises one 90-bit packed expression result into 18 extended field beats.
// Optional running XOR of the frame's fields on out_xsum: EXPR_UNPACK_XSUM_EN.
module expr_result_unpacker
    import expr_bus_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TOTAL_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_idx,
    output logic [OUT_W-1:0]   out_field,
    output logic               out_signed,
    output logic               out_last
`ifdef EXPR_UNPACK_XSUM_EN
    ,
    output logic [OUT_W-1:0]   out_xsum
`endif
);

    state_e             state_q, state_d;
    logic [TOTAL_W-1:0] sr_q, sr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FW_W-1:0]    cur_w;
    logic               cur_signed;
    logic               cur_last;
    field_t             cur_field;
`ifdef EXPR_UNPACK_XSUM_EN
    field_t             xsum_q, xsum_d;
`endif

    assign cur_w      = field_width(idx_q);
    assign cur_signed = field_signed(idx_q);
    assign cur_last   = (idx_q == IDX_W'(NUM_FIELDS - 1));

    expr_field_extend u_extend (
        .top_bits_i (sr_q[TOTAL_W-1 -: OUT_W]),
        .width_i    (cur_w),
        .signed_i   (cur_signed),
        .field_o    (cur_field)
    );

    // State, shift register and field index; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            idx_q   <= '0;
`ifdef EXPR_UNPACK_XSUM_EN
            xsum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
`ifdef EXPR_UNPACK_XSUM_EN
            xsum_q  <= xsum_d;
`endif
        end
    end

    // Next state and handshakes; a last beat can overlap the next word capture.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        idx_d      = idx_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_idx    = idx_q;
        out_field  = '0;
        out_signed = 1'b0;
        out_last   = 1'b0;
`ifdef EXPR_UNPACK_XSUM_EN
        xsum_d     = xsum_q;
        out_xsum   = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sr_d    = in_data;
                    idx_d   = '0;
                    state_d = ST_EMIT;
`ifdef EXPR_UNPACK_XSUM_EN
                    xsum_d  = '0;
`endif
                end
            end
            ST_EMIT: begin
                out_valid  = 1'b1;
                out_field  = cur_field;
                out_signed = cur_signed;
                out_last   = cur_last;
`ifdef EXPR_UNPACK_XSUM_EN
                out_xsum   = xsum_q ^ cur_field;
`endif
                if (out_ready) begin
                    if (cur_last) begin
                        in_ready = 1'b1;
                        idx_d    = '0;
`ifdef EXPR_UNPACK_XSUM_EN
                        xsum_d   = '0;
`endif
                        if (in_valid) begin
                            sr_d = in_data;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        sr_d  = sr_q << cur_w;
                        idx_d = idx_q + IDX_W'(1);
`ifdef EXPR_UNPACK_XSUM_EN
                        xsum_d = xsum_q ^ cur_field;
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_expr_result_unpacker.sv
// Scoreboard bench for expr_result_unpacker: words accepted on the input are
// expanded by a reference model into expected beats; a monitor pops and compares.
module tb_expr_result_unpacker;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [89:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [5:0]  out_field;
    logic        out_signed;
    logic        out_last;
`ifdef EXPR_UNPACK_XSUM_EN
    logic [5:0]  out_xsum;
`endif

    expr_result_unpacker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_field  (out_field),
        .out_signed (out_signed),
        .out_last   (out_last)
`ifdef EXPR_UNPACK_XSUM_EN
        ,
        .out_xsum   (out_xsum)
`endif
    );

    typedef struct packed {
        logic [4:0] idx;
        logic [5:0] field;
        logic       sg;
        logic       last;
        logic [5:0] xs;
    } beat_t;

    beat_t q[$];
    int    errors = 0;
    int    checks = 0;
    int    rdy_mode = 0;
    int    hold = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference model: slice fields MSB-first by arithmetic and extend as integers.
    task automatic build(input logic [89:0] d);
        int          off;
        int          w;
        int          raw;
        int          v;
        bit          sg;
        logic [89:0] t;
        logic [5:0]  xs;
        beat_t       b;
        off = 0;
        xs  = '0;
        for (int i = 0; i < 18; i++) begin
            w   = 4 + (i % 3);
            sg  = ((i / 3) % 2) == 1;
            t   = d >> (90 - off - w);
            raw = int'(t[5:0]) & ((1 << w) - 1);
            v   = (sg && raw >= (1 << (w - 1))) ? raw - (1 << w) : raw;
            b.idx   = 5'(i);
            b.field = 6'(v);
            b.sg    = sg;
            b.last  = (i == 17);
            xs      = xs ^ b.field;
            b.xs    = xs;
            q.push_back(b);
            off += w;
        end
    endtask

    // Monitor: checks both interfaces every cycle on the falling edge.
    always @(negedge clk) begin
        beat_t e;
        bit    exp_v;
        bit    exp_ir;
        if (!rst_n) begin
            chk("rst_out_valid",  int'(out_valid),  0);
            chk("rst_in_ready",   int'(in_ready),   1);
            chk("rst_out_idx",    int'(out_idx),    0);
            chk("rst_out_field",  int'(out_field),  0);
            chk("rst_out_signed", int'(out_signed), 0);
            chk("rst_out_last",   int'(out_last),   0);
            q.delete();
        end else begin
            exp_v = (q.size() != 0);
            chk("out_valid", int'(out_valid), int'(exp_v));
            if (exp_v) begin
                e = q[0];
                chk("out_idx",    int'(out_idx),    int'(e.idx));
                chk("out_field",  int'(out_field),  int'(e.field));
                chk("out_signed", int'(out_signed), int'(e.sg));
                chk("out_last",   int'(out_last),   int'(e.last));
`ifdef EXPR_UNPACK_XSUM_EN
                chk("out_xsum",   int'(out_xsum),   int'(e.xs));
`endif
                exp_ir = e.last && out_ready;
                if (out_ready) void'(q.pop_front());
            end else begin
                exp_ir = 1'b1;
            end
            chk("in_ready", int'(in_ready), int'(exp_ir));
            if (in_valid && exp_ir) build(in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (hold > 0) begin
            out_ready = 1'b0;
            hold--;
        end else begin
            out_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic send_word(input logic [89:0] d);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 300 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) timeout_fail("send_word");
    endtask

    task automatic wait_idx(input int n);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 300 && !hit; k++) begin
            if (out_valid && out_idx == 5'(n)) hit = 1'b1;
            else tick();
        end
        if (!hit) timeout_fail("wait_idx");
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 1000 && !done; k++) begin
            if (q.size() == 0 && !out_valid) done = 1'b1;
            else tick();
        end
        if (!done) timeout_fail("drain");
    endtask

    function automatic logic [89:0] rand_word();
        logic [89:0] w;
        w = {$urandom, $urandom, $urandom};
        return w;
    endfunction

    initial begin
        logic [89:0] d;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // All-zero word, always ready.
        send_word('0);
        drain();

        // y0 = 4'b1000 unsigned, y3 = 4'b1000 signed.
        d = '0;
        d[89:86] = 4'b1000;
        d[74:71] = 4'b1000;
        send_word(d);
        drain();

        // All ones: unsigned 15/31/63, signed -1.
        send_word('1);
        drain();

        // Three-cycle stall on beat 5.
        send_word(rand_word());
        wait_idx(4);
        hold = 3;
        drain();

        // Reset in the middle of a frame, then a fresh word.
        send_word(rand_word());
        wait_idx(9);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        send_word(rand_word());
        drain();

        // Two words back to back.
        send_word(rand_word());
        send_word(rand_word());
        drain();

        // Random backpressure and random gaps.
        rdy_mode = 1;
        for (int i = 0; i < 20; i++) begin
            send_word(rand_word());
            repeat ($urandom_range(0, 4)) tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
